// File: rtl/vga_pattern_if.sv
`default_nettype none
// vga_pattern_if: timing-generator inputs and DAC-side outputs of the pattern source.
// Revision 1.0
interface vga_pattern_if;
  logic [10:0] pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        hsync;
  logic        vsync;
  logic        next_pattern;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        hsync_out;
  logic        vsync_out;
  logic        video_on_out;
  logic [1:0]  pattern_sel;
  logic        frame_start;

  modport master (
    output pixel_x, pixel_y, video_on, hsync, vsync, next_pattern,
    input  red, green, blue, hsync_out, vsync_out, video_on_out, pattern_sel, frame_start
  );

  modport slave (
    input  pixel_x, pixel_y, video_on, hsync, vsync, next_pattern,
    output red, green, blue, hsync_out, vsync_out, video_on_out, pattern_sel, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// vga_pattern_gen: XGA four-pattern pixel source, 2-cycle RGB/sync pipeline.
// Macro PATTERN_AUTOCYCLE_EN enables timed pattern cycling. Revision 1.0
module vga_pattern_gen #(
  parameter int H_ACTIVE           = 1024,
  parameter int V_ACTIVE           = 768,
  parameter int SYNC_ACTIVE_LOW    = 1,
  parameter int BOX_SIZE           = 64,
  parameter int BOX_STEP           = 4,
  parameter int FRAMES_PER_PATTERN = 120
) (
  input  logic         clk,
  input  logic         reset,
  vga_pattern_if.slave vif
);

  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    BARS     = 2'd0,
    CHECKER  = 2'd1,
    GRADIENT = 2'd2,
    BOX      = 2'd3
  } pattern_t;

  pattern_t    state, state_next;
  logic [10:0] x1;
  logic [9:0]  y1;
  logic        von1, hs1, vs1;
  logic        vs_act, vs_act_prev, frame_start_q;
  logic        pending, manual_adv, advance;
  logic [7:0]  frame_count;
  logic [10:0] bx, bx_next;
  logic [9:0]  by, by_next;
  logic        bx_neg, bx_neg_next, by_neg, by_neg_next;
  logic [3:0]  pix_r, pix_g, pix_b;
  logic [3:0]  red_q, green_q, blue_q;
  logic        hs_q, vs_q, von_q;
  logic        in_box;
  logic [2:0]  bar_idx;
  logic        checker_on;

  // XOR with the idle level turns either polarity into an active-high flag.
  assign vs_act     = vif.vsync ^ SYNC_IDLE;
  assign manual_adv = frame_start_q && (pending || vif.next_pattern);

`ifdef PATTERN_AUTOCYCLE_EN
  localparam int AUTO_W = (FRAMES_PER_PATTERN > 2) ? $clog2(FRAMES_PER_PATTERN) : 1;
  logic [AUTO_W-1:0] auto_count;
  logic              auto_hit;

  assign auto_hit = frame_start_q && (auto_count == AUTO_W'(FRAMES_PER_PATTERN - 1));
  assign advance  = manual_adv || auto_hit;

  // Any advance, manual or timed, restarts the dwell period.
  always_ff @(posedge clk) begin
    if (reset) begin
      auto_count <= '0;
    end else if (frame_start_q) begin
      if (advance) auto_count <= '0;
      else         auto_count <= auto_count + 1'b1;
    end
  end
`else
  assign advance = manual_adv;
`endif

  always_comb begin
    state_next = BARS;
    case (state)
      BARS:     state_next = CHECKER;
      CHECKER:  state_next = GRADIENT;
      GRADIENT: state_next = BOX;
      BOX:      state_next = BARS;
      default:  state_next = BARS;
    endcase
  end

  // Bounce: clamp to the wall and reverse when the next step would cross it.
  always_comb begin
    bx_next     = bx;
    bx_neg_next = bx_neg;
    by_next     = by;
    by_neg_next = by_neg;
    if (!bx_neg) begin
      if ({1'b0, bx} + 12'(BOX_STEP + BOX_SIZE) > 12'(H_ACTIVE)) begin
        bx_next     = 11'(H_ACTIVE - BOX_SIZE);
        bx_neg_next = 1'b1;
      end else begin
        bx_next = bx + 11'(BOX_STEP);
      end
    end else if (bx < 11'(BOX_STEP)) begin
      bx_next     = '0;
      bx_neg_next = 1'b0;
    end else begin
      bx_next = bx - 11'(BOX_STEP);
    end
    if (!by_neg) begin
      if ({1'b0, by} + 11'(BOX_STEP + BOX_SIZE) > 11'(V_ACTIVE)) begin
        by_next     = 10'(V_ACTIVE - BOX_SIZE);
        by_neg_next = 1'b1;
      end else begin
        by_next = by + 10'(BOX_STEP);
      end
    end else if (by < 10'(BOX_STEP)) begin
      by_next     = '0;
      by_neg_next = 1'b0;
    end else begin
      by_next = by - 10'(BOX_STEP);
    end
  end

  assign bar_idx    = x1[9:7];
  assign checker_on = x1[6] ^ y1[6];
  assign in_box     = ({1'b0, x1} >= {1'b0, bx}) && ({1'b0, x1} < {1'b0, bx} + 12'(BOX_SIZE)) &&
                      ({1'b0, y1} >= {1'b0, by}) && ({1'b0, y1} < {1'b0, by} + 11'(BOX_SIZE));

  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    case (state)
      BARS: begin
        pix_r = {4{~bar_idx[1]}};
        pix_g = {4{~bar_idx[2]}};
        pix_b = {4{~bar_idx[0]}};
      end
      CHECKER: begin
        pix_r = {4{checker_on}};
        pix_g = {4{checker_on}};
        pix_b = {4{checker_on}};
      end
      GRADIENT: begin
        pix_r = x1[9:6];
        pix_g = y1[9:6];
        pix_b = frame_count[7:4];
      end
      BOX: begin
        pix_r = in_box ? 4'hF : 4'h0;
        pix_g = in_box ? 4'hF : 4'h0;
        pix_b = in_box ? 4'hF : 4'h4;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x1            <= '0;
      y1            <= '0;
      von1          <= 1'b0;
      hs1           <= SYNC_IDLE;
      vs1           <= SYNC_IDLE;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      hs_q          <= SYNC_IDLE;
      vs_q          <= SYNC_IDLE;
      von_q         <= 1'b0;
      vs_act_prev   <= 1'b0;
      frame_start_q <= 1'b0;
      pending       <= 1'b0;
      frame_count   <= '0;
      bx            <= '0;
      by            <= '0;
      bx_neg        <= 1'b0;
      by_neg        <= 1'b0;
      state         <= BARS;
    end else begin
      x1            <= vif.pixel_x;
      y1            <= vif.pixel_y;
      von1          <= vif.video_on;
      hs1           <= vif.hsync;
      vs1           <= vif.vsync;
      red_q         <= von1 ? pix_r : 4'h0;
      green_q       <= von1 ? pix_g : 4'h0;
      blue_q        <= von1 ? pix_b : 4'h0;
      hs_q          <= hs1;
      vs_q          <= vs1;
      von_q         <= von1;
      vs_act_prev   <= vs_act;
      frame_start_q <= vs_act && !vs_act_prev;
      if (frame_start_q) begin
        pending     <= 1'b0;
        frame_count <= frame_count + 8'd1;
        bx          <= bx_next;
        by          <= by_next;
        bx_neg      <= bx_neg_next;
        by_neg      <= by_neg_next;
      end else if (vif.next_pattern) begin
        pending <= 1'b1;
      end
      if (advance) state <= state_next;
    end
  end

  assign vif.red          = red_q;
  assign vif.green        = green_q;
  assign vif.blue         = blue_q;
  assign vif.hsync_out    = hs_q;
  assign vif.vsync_out    = vs_q;
  assign vif.video_on_out = von_q;
  assign vif.pattern_sel  = state;
  assign vif.frame_start  = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`timescale 1ns/1ps
`default_nettype none
// tb_vga_pattern_gen: directed + randomized checks against a frame-level reference model.
// Revision 1.0
module tb_vga_pattern_gen;
  localparam int TB_FPP = 3;

  logic clk = 1'b0;
  logic reset;
  int   total  = 0;
  int   passed = 0;

  // Reference model state, updated once per emulated frame boundary.
  int       m_pat, m_bx, m_by, m_auto;
  bit       m_pend, m_bxn, m_byn;
  logic [7:0] m_fc;

  always #5 clk = ~clk;

  vga_pattern_if vif ();

  vga_pattern_gen #(.FRAMES_PER_PATTERN(TB_FPP)) dut (
    .clk   (clk),
    .reset (reset),
    .vif   (vif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] rgb_now();
    return {vif.red, vif.green, vif.blue};
  endfunction

  task automatic model_reset();
    m_pat = 0; m_bx = 0; m_by = 0; m_auto = 0;
    m_pend = 0; m_bxn = 0; m_byn = 0; m_fc = 8'd0;
  endtask

  function automatic void bounce(inout int pos, inout bit neg, input int limit);
    if (!neg) begin
      if (pos + 4 + 64 > limit) begin pos = limit - 64; neg = 1; end
      else pos = pos + 4;
    end else begin
      if (pos < 4) begin pos = 0; neg = 0; end
      else pos = pos - 4;
    end
  endfunction

  task automatic model_frame(input bit pulse_now);
    bit man, hit;
    man  = m_pend || pulse_now;
    hit  = 0;
    m_fc = m_fc + 8'd1;
    bounce(m_bx, m_bxn, 1024);
    bounce(m_by, m_byn, 768);
`ifdef PATTERN_AUTOCYCLE_EN
    hit = (m_auto == TB_FPP - 1);
    if (man || hit) m_auto = 0;
    else m_auto = m_auto + 1;
`endif
    if (man || hit) m_pat = (m_pat + 1) % 4;
    m_pend = 0;
  endtask

  function automatic logic [11:0] exp_rgb(input int x, input int y, input bit von);
    logic [11:0] bars [8];
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    if (!von) return 12'h000;
    case (m_pat)
      0: return bars[x / 128];
      1: return (((x / 64) % 2) != ((y / 64) % 2)) ? 12'hFFF : 12'h000;
      2: return {4'((x / 64) % 16), 4'(y / 64), 4'(int'(m_fc) / 16)};
      default: return (x >= m_bx && x < m_bx + 64 && y >= m_by && y < m_by + 64) ? 12'hFFF : 12'h004;
    endcase
  endfunction

  task automatic drive_idle();
    vif.pixel_x = '0; vif.pixel_y = '0; vif.video_on = 1'b0;
    vif.hsync = 1'b1; vif.vsync = 1'b1; vif.next_pattern = 1'b0;
  endtask

  // Streams a new pixel every cycle and checks each one exactly two cycles later.
  task automatic stream(input int n, input int near_box);
    logic [13:0] q[$];
    logic [13:0] e;
    for (int i = 0; i <= n; i++) begin
      int x, y;
      bit von, hs;
      if (i < n) begin
        if (near_box != 0) begin
          x = m_bx - 2 + int'($urandom_range(0, 67));
          y = m_by - 2 + int'($urandom_range(0, 67));
          if (x < 0) x = 0;
          if (x > 1023) x = 1023;
          if (y < 0) y = 0;
          if (y > 767) y = 767;
          von = 1;
        end else begin
          x   = int'($urandom_range(0, 1023));
          y   = int'($urandom_range(0, 767));
          von = ($urandom_range(0, 7) != 0);
        end
        hs = bit'($urandom_range(0, 1));
      end else begin
        x = 0; y = 0; von = 0; hs = 1;
      end
      vif.pixel_x  = 11'(x);
      vif.pixel_y  = 10'(y);
      vif.video_on = von;
      vif.hsync    = hs;
      q.push_back({exp_rgb(x, y, von), hs, von});
      tick();
      if (q.size() == 2) begin
        e = q.pop_front();
        chk("rgb", 32'(rgb_now()), 32'(e[13:2]));
        chk("hsync_out", 32'(vif.hsync_out), 32'(e[1]));
        chk("video_on_out", 32'(vif.video_on_out), 32'(e[0]));
        chk("vsync_out_idle", 32'(vif.vsync_out), 32'd1);
        chk("pattern_midframe", 32'(vif.pattern_sel), 32'(m_pat));
      end
    end
  endtask

  task automatic pulse();
    vif.next_pattern = 1'b1;
    m_pend = 1;
    tick();
    vif.next_pattern = 1'b0;
    tick();
  endtask

  task automatic frame(input bit pulse_same);
    vif.vsync = 1'b0;
    tick();
    chk("frame_start_pulse", 32'(vif.frame_start), 32'd1);
    chk("pattern_before_edge", 32'(vif.pattern_sel), 32'(m_pat));
    vif.next_pattern = pulse_same;
    tick();
    vif.next_pattern = 1'b0;
    model_frame(pulse_same);
    chk("frame_start_single", 32'(vif.frame_start), 32'd0);
    chk("vsync_out_active", 32'(vif.vsync_out), 32'd0);
    chk("pattern_after_edge", 32'(vif.pattern_sel), 32'(m_pat));
    vif.vsync = 1'b1;
    tick();
    tick();
    chk("vsync_out_release", 32'(vif.vsync_out), 32'd1);
  endtask

  initial begin
    int seq [10];
`ifdef PATTERN_AUTOCYCLE_EN
    seq = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3};
`else
    seq = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
    drive_idle();
    model_reset();

    // Reset with toggling inputs
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vif.pixel_x      = 11'($urandom_range(0, 1023));
      vif.pixel_y      = 10'($urandom_range(0, 767));
      vif.video_on     = bit'($urandom_range(0, 1));
      vif.hsync        = bit'($urandom_range(0, 1));
      vif.vsync        = bit'($urandom_range(0, 1));
      vif.next_pattern = bit'($urandom_range(0, 1));
      tick();
    end
    chk("reset_rgb", 32'(rgb_now()), 32'd0);
    chk("reset_hsync_out", 32'(vif.hsync_out), 32'd1);
    chk("reset_vsync_out", 32'(vif.vsync_out), 32'd1);
    chk("reset_video_on_out", 32'(vif.video_on_out), 32'd0);
    chk("reset_pattern", 32'(vif.pattern_sel), 32'd0);
    chk("reset_frame_start", 32'(vif.frame_start), 32'd0);
    drive_idle();
    reset = 1'b0;
    tick();
    tick();

    // Colour bars, directed
    vif.pixel_x = 11'd130; vif.pixel_y = 10'd0; vif.video_on = 1'b1;
    tick(); tick();
    chk("bars_yellow", 32'(rgb_now()), 32'hFF0);
    vif.pixel_x = 11'd1023;
    tick(); tick();
    chk("bars_black", 32'(rgb_now()), 32'h000);
    vif.pixel_x = 11'd0; vif.video_on = 1'b0;
    tick(); tick();
    chk("blank_forces_zero", 32'(rgb_now()), 32'h000);
    stream(24, 0);

    // Multiple requests in one frame give one advance
    pulse(); pulse(); pulse();
    chk("pattern_held_midframe", 32'(vif.pattern_sel), 32'd0);
    frame(1'b0);
    chk("pattern_one_step", 32'(vif.pattern_sel), 32'd1);
    stream(24, 0);
    frame(1'b0);
    chk("pattern_no_request", 32'(vif.pattern_sel), 32'd1);

    pulse(); frame(1'b0);
    stream(24, 0);
    pulse(); frame(1'b0);
    chk("pattern_box", 32'(vif.pattern_sel), 32'd3);
    stream(24, 1);
    frame(1'b1);
    chk("pattern_wrap_coincident", 32'(vif.pattern_sel), 32'd0);

    // Drive into BOX and let the square bounce off all four walls
    pulse(); frame(1'b0);
    pulse(); frame(1'b0);
    pulse(); frame(1'b0);
    for (int f = 0; f < 500; f++) begin
      stream(4, 1);
      frame(1'b0);
    end

    // Randomized requests and pixels across all patterns
    for (int f = 0; f < 40; f++) begin
      int k;
      k = int'($urandom_range(0, 3));
      for (int p = 0; p < k; p++) begin
        stream(3, 0);
        pulse();
      end
      stream(12, ($urandom_range(0, 1) != 0) ? 1 : 0);
      frame($urandom_range(0, 3) == 0);
    end

    // Reset mid-frame, then free-running frames with no requests
    vif.video_on = 1'b1;
    vif.pixel_x  = 11'd300;
    reset = 1'b1;
    tick();
    chk("midreset_pattern", 32'(vif.pattern_sel), 32'd0);
    chk("midreset_rgb", 32'(rgb_now()), 32'd0);
    chk("midreset_video_on_out", 32'(vif.video_on_out), 32'd0);
    chk("midreset_hsync_out", 32'(vif.hsync_out), 32'd1);
    reset = 1'b0;
    drive_idle();
    model_reset();
    tick();
    for (int f = 0; f < 10; f++) begin
      frame(1'b0);
      chk("free_run_sequence", 32'(vif.pattern_sel), 32'(seq[f]));
      stream(6, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
